// File: rtl/uart_pkg.sv
// Shared types and elaboration-time helpers for the buffered UART.
package uart_pkg;

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

   function automatic int CeilLog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Clocks per bit, rounded down.
   function automatic int uart_div(input int clk_freq, input int baudrate);
      return clk_freq / baudrate;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push on a full FIFO is accepted
// only when a pop happens in the same cycle. Head reads 0 while empty.
module uart_fifo
   import uart_pkg::*;
#(
   parameter int width = 8,
   parameter int depth = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [width-1:0] wdata,
   output logic [width-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = CeilLog2(depth);

   logic [width-1:0] mem [depth];
   logic [AW:0]      wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/uart_buffered.sv
// Full-duplex UART with TX/RX FIFOs and sticky error flags.
// Define UART_PARITY_EN to add a parity bit (sense set by parity_odd).
module uart_buffered
   import uart_pkg::*;
#(
   parameter int Nbit       = 8,
   parameter int baudrate   = 9600,
   parameter int clk_freq   = 50000000,
   parameter int fifo_depth = 4,
   parameter int parity_odd = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            SerialDataIn,
   input  logic            Transmit,
   input  logic [Nbit-1:0] DataTx,
   input  logic            Rx_pop,
   input  logic            clr_error,
   output logic            SerialDataOut,
   output logic            Tx_full,
   output logic            Tx_busy,
   output logic [Nbit-1:0] DataRx,
   output logic            Rx_flag,
   output logic            Rx_overrun,
   output logic            Parity_error,
   output logic            Frame_error
);

`ifdef UART_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   localparam int DIV  = uart_div(clk_freq, baudrate);
   localparam int CW   = CeilLog2(DIV + 1);
   localparam int IW   = CeilLog2(Nbit);
   localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);
   localparam logic [IW-1:0] LAST_BIT = IW'(Nbit - 1);
   localparam logic          PODD     = (parity_odd != 0);

   // ---------------- TX ----------------
   tx_state_t       tx_state, tx_next;
   logic [CW-1:0]   tx_cnt, tx_cnt_n;
   logic [Nbit-1:0] tx_data, tx_data_n, tx_head;
   logic [IW-1:0]   tx_bit, tx_bit_n;
   logic            tx_line, tx_line_n, tx_pop, tx_empty;

   uart_fifo #(.width(Nbit), .depth(fifo_depth)) u_tx_fifo (
      .clk(clk), .reset(reset), .push(Transmit & ~Tx_full), .pop(tx_pop),
      .wdata(DataTx), .rdata(tx_head), .full(Tx_full), .empty(tx_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_data  <= '0;
         tx_bit   <= '0;
         tx_line  <= 1'b1;
      end else begin
         tx_state <= tx_next;
         tx_cnt   <= tx_cnt_n;
         tx_data  <= tx_data_n;
         tx_bit   <= tx_bit_n;
         tx_line  <= tx_line_n;
      end
   end

   always_comb begin
      tx_next   = tx_state;
      tx_cnt_n  = tx_cnt + 1'b1;
      tx_data_n = tx_data;
      tx_bit_n  = tx_bit;
      tx_line_n = tx_line;
      tx_pop    = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            tx_cnt_n  = '0;
            tx_line_n = 1'b1;
            if (!tx_empty) begin
               tx_pop    = 1'b1;
               tx_data_n = tx_head;
               tx_line_n = 1'b0;
               tx_next   = TX_START;
            end
         end
         TX_START: if (tx_cnt == BIT_END) begin
            tx_cnt_n  = '0;
            tx_bit_n  = '0;
            tx_line_n = tx_data[0];
            tx_next   = TX_DATA;
         end
         TX_DATA: if (tx_cnt == BIT_END) begin
            tx_cnt_n = '0;
            if (tx_bit == LAST_BIT) begin
               if (PAR_EN) begin
                  tx_line_n = (^tx_data) ^ PODD;
                  tx_next   = TX_PARITY;
               end else begin
                  tx_line_n = 1'b1;
                  tx_next   = TX_STOP;
               end
            end else begin
               tx_bit_n  = tx_bit + 1'b1;
               tx_line_n = tx_data[tx_bit_n];
            end
         end
         TX_PARITY: if (tx_cnt == BIT_END) begin
            tx_cnt_n  = '0;
            tx_line_n = 1'b1;
            tx_next   = TX_STOP;
         end
         TX_STOP: if (tx_cnt == BIT_END) begin
            tx_cnt_n = '0;
            // Queued data chains straight into the next start bit.
            if (!tx_empty) begin
               tx_pop    = 1'b1;
               tx_data_n = tx_head;
               tx_line_n = 1'b0;
               tx_next   = TX_START;
            end else begin
               tx_line_n = 1'b1;
               tx_next   = TX_IDLE;
            end
         end
         default: tx_next = TX_IDLE;
      endcase
   end

   assign SerialDataOut = tx_line;
   assign Tx_busy       = !tx_empty || (tx_state != TX_IDLE);

   // ---------------- RX ----------------
   rx_state_t       rx_state, rx_next;
   logic [CW-1:0]   rx_cnt, rx_cnt_n;
   logic [Nbit-1:0] rx_sh, rx_sh_n;
   logic [IW-1:0]   rx_bit, rx_bit_n;
   logic            rx_s1, rx_s2, rx_prev;
   logic            rx_pbad, rx_pbad_n, rx_done, rx_full, rx_empty;
   logic            ovr_q, par_q, frm_q;

   uart_fifo #(.width(Nbit), .depth(fifo_depth)) u_rx_fifo (
      .clk(clk), .reset(reset), .push(rx_done), .pop(Rx_pop),
      .wdata(rx_sh), .rdata(DataRx), .full(rx_full), .empty(rx_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_prev  <= 1'b1;
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_sh    <= '0;
         rx_bit   <= '0;
         rx_pbad  <= 1'b0;
      end else begin
         rx_s1    <= SerialDataIn;
         rx_s2    <= rx_s1;
         rx_prev  <= rx_s2;
         rx_state <= rx_next;
         rx_cnt   <= rx_cnt_n;
         rx_sh    <= rx_sh_n;
         rx_bit   <= rx_bit_n;
         rx_pbad  <= rx_pbad_n;
      end
   end

   always_comb begin
      rx_next   = rx_state;
      rx_cnt_n  = rx_cnt + 1'b1;
      rx_sh_n   = rx_sh;
      rx_bit_n  = rx_bit;
      rx_pbad_n = rx_pbad;
      rx_done   = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            rx_cnt_n = '0;
            if (rx_prev && !rx_s2) begin
               rx_pbad_n = 1'b0;
               rx_next   = RX_START;
            end
         end
         RX_START: if (rx_cnt == HALF_END) begin
            rx_cnt_n = '0;
            rx_bit_n = '0;
            rx_next  = rx_s2 ? RX_IDLE : RX_DATA;
         end
         RX_DATA: if (rx_cnt == BIT_END) begin
            rx_cnt_n = '0;
            rx_sh_n  = {rx_s2, rx_sh[Nbit-1:1]};
            if (rx_bit == LAST_BIT) rx_next = PAR_EN ? RX_PARITY : RX_STOP;
            else                    rx_bit_n = rx_bit + 1'b1;
         end
         RX_PARITY: if (rx_cnt == BIT_END) begin
            rx_cnt_n  = '0;
            rx_pbad_n = rx_s2 ^ (^rx_sh) ^ PODD;
            rx_next   = RX_STOP;
         end
         RX_STOP: if (rx_cnt == BIT_END) begin
            rx_cnt_n = '0;
            rx_done  = 1'b1;
            rx_next  = RX_IDLE;
         end
         default: rx_next = RX_IDLE;
      endcase
   end

   // Sticky flags; clr_error wins over a same-cycle set.
   always_ff @(posedge clk) begin
      if (reset || clr_error) begin
         ovr_q <= 1'b0;
         par_q <= 1'b0;
         frm_q <= 1'b0;
      end else begin
         if (rx_done && rx_full && !Rx_pop) ovr_q <= 1'b1;
         if (rx_done && rx_pbad)            par_q <= 1'b1;
         if (rx_done && !rx_s2)             frm_q <= 1'b1;
      end
   end

   assign Rx_flag      = !rx_empty;
   assign Rx_overrun   = ovr_q;
   assign Frame_error  = frm_q;
   assign Parity_error = PAR_EN && par_q;

endmodule
